// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the ARM multicycle control unit.
package arm_mc_pkg;

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR,
        MEMRD, MEMWR, MEMWB, LINK, BRANCH, FAULT
    } state_t;

    // Instruction register bits [31:12]
    typedef struct packed {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rn;
        logic [3:0] rd;
    } instr_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_EOR   = 3'b100;
    localparam logic [2:0] ALU_PASSB = 3'b101;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] SRCB_ZERO = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_BR = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    function automatic logic cmd_legal(logic [3:0] cmd);
        case (cmd)
            CMD_AND, CMD_EOR, CMD_SUB, CMD_ADD,
            CMD_TST, CMD_CMP, CMD_ORR, CMD_MOV: cmd_legal = 1'b1;
            default:                            cmd_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] cmd_alu(logic [3:0] cmd);
        case (cmd)
            CMD_SUB, CMD_CMP: cmd_alu = ALU_SUB;
            CMD_AND, CMD_TST: cmd_alu = ALU_AND;
            CMD_ORR:          cmd_alu = ALU_ORR;
            CMD_EOR:          cmd_alu = ALU_EOR;
            CMD_MOV:          cmd_alu = ALU_PASSB;
            default:          cmd_alu = ALU_ADD;
        endcase
    endfunction

    // Arithmetic ops own C and V; logical ops leave them alone
    function automatic logic cmd_arith(logic [3:0] cmd);
        cmd_arith = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
    endfunction

endpackage

// File: rtl/arm_mc_if.sv
// Controller <-> multicycle datapath signal bundle.
interface arm_mc_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic        LinkWr;
    logic [1:0]  RegSrc;
    logic [1:0]  ImmSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic [1:0]  ResultSrc;
    logic [3:0]  Flags;
    logic        Fault;

    modport master (
        input  Instr, ALUFlags, MemReady,
        output PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, LinkWr,
               RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc, Flags, Fault
    );

    modport slave (
        output Instr, ALUFlags, MemReady,
        input  PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, LinkWr,
               RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc, Flags, Fault
    );
endinterface

// File: rtl/arm_mc_condunit.sv
// NZCV flag register with split NZ/CV write enables and condition-code evaluation.
module arm_mc_condunit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_write,
    output logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v, ge;

    assign {n, z, c, v} = flags;
    assign ge = (n == v);

    // flag_write[1] loads N,Z; flag_write[0] loads C,V
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else begin
            if (flag_write[1]) flags[3:2] <= alu_flags[3:2];
            if (flag_write[0]) flags[1:0] <= alu_flags[1:0];
        end
    end

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~(c & ~z);
            4'b1010: cond_ex = ge;
            4'b1011: cond_ex = ~ge;
            4'b1100: cond_ex = ~z & ge;
            4'b1101: cond_ex = ~(~z & ge);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Moore-FSM control unit for the shared-memory multicycle ARM datapath,
// with memory wait-state handling and a sticky fault state.
module arm_mc_controller
    import arm_mc_pkg::*;
#(
    parameter bit          HAS_BL     = 1'b1,
    parameter bit          MEMRDY_EN  = 1'b1,
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic     clk,
    input  logic     reset,
    arm_mc_if.master bus
);

    state_t              state_q, state_n;
    logic [WAIT_W-1:0]   wait_q;
    instr_t              ins;
    logic                mrdy, cond_ex, wait_hit, waiting;
    logic                no_write, illegal, rd15, s_bit;
    logic [3:0]          cmd;
    logic [1:0]          flag_write;
    logic                pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, link_wr;
    logic [1:0]          reg_src, imm_src, alu_src_b, result_src;
    logic                alu_src_a;
    logic [2:0]          alu_control;
    logic                unused_rn;

    assign ins       = instr_t'(bus.Instr);
    assign unused_rn = ^ins.rn;
    assign mrdy      = MEMRDY_EN ? bus.MemReady : 1'b1;
    assign cmd       = ins.funct[4:1];
    assign s_bit     = ins.funct[0];
    assign rd15      = (ins.rd == 4'hF);
    assign no_write  = (cmd == CMD_CMP) || (cmd == CMD_TST);
    assign waiting   = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign wait_hit  = ~mrdy && (wait_q == WAIT_W'(WAIT_LIMIT - 1));

    // Encodings the unit refuses to execute
    assign illegal = ((ins.op == 2'b00) && (!cmd_legal(cmd) || (no_write && !s_bit)))
                   || ((ins.op == 2'b10) && ins.funct[4] && !HAS_BL)
                   || (ins.op == 2'b11);

    arm_mc_condunit u_cond (
        .clk        (clk),
        .reset      (reset),
        .cond       (ins.cond),
        .alu_flags  (bus.ALUFlags),
        .flag_write (flag_write),
        .flags      (bus.Flags),
        .cond_ex    (cond_ex)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_n;
            if (state_n != state_q)    wait_q <= '0;
            else if (waiting && !mrdy) wait_q <= wait_q + WAIT_W'(1);
        end
    end

    always_comb begin
        state_n     = state_q;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        link_wr     = 1'b0;
        reg_src     = 2'b00;
        imm_src     = IMM_8;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        alu_control = ALU_ADD;
        result_src  = RES_ALUOUT;
        flag_write  = 2'b00;

        case (state_q)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                if (mrdy) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_n  = DECODE;
                end else if (wait_hit) begin
                    state_n  = FAULT;
                end
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                if (ins.cond == 4'hF)  state_n = FAULT;
                else if (!cond_ex)     state_n = FETCH;
                else if (illegal)      state_n = FAULT;
                else begin
                    case (ins.op)
                        2'b00:   state_n = ins.funct[5] ? EXECI : EXECR;
                        2'b01:   state_n = MEMADR;
                        2'b10:   state_n = (ins.funct[4] && HAS_BL) ? LINK : BRANCH;
                        default: state_n = FAULT;
                    endcase
                end
            end
            EXECR, EXECI: begin
                alu_src_b   = (state_q == EXECI) ? SRCB_IMM : SRCB_REG;
                imm_src     = IMM_8;
                alu_control = cmd_alu(cmd);
                if (s_bit) flag_write = {1'b1, cmd_arith(cmd)};
                state_n     = no_write ? FETCH : ALUWB;
            end
            ALUWB: begin
                result_src = RES_ALUOUT;
                pc_write   = rd15;
                reg_write  = ~rd15;
                state_n    = FETCH;
            end
            MEMADR: begin
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_12;
                state_n   = ins.funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (mrdy)          state_n = MEMWB;
                else if (wait_hit) state_n = FAULT;
            end
            MEMWR: begin
                adr_src   = 1'b1;
                reg_src   = 2'b10;
                mem_write = 1'b1;
                if (mrdy)          state_n = FETCH;
                else if (wait_hit) state_n = FAULT;
            end
            MEMWB: begin
                result_src = RES_DATA;
                pc_write   = rd15;
                reg_write  = ~rd15;
                state_n    = FETCH;
            end
            // R14 <- PC, which already holds the return address after fetch
            LINK: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_ZERO;
                result_src = RES_ALURESULT;
                reg_write  = 1'b1;
                link_wr    = 1'b1;
                state_n    = BRANCH;
            end
            BRANCH: begin
                reg_src    = 2'b01;
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_BR;
                result_src = RES_ALURESULT;
                pc_write   = 1'b1;
                state_n    = FETCH;
            end
            FAULT:   state_n = FAULT;
            default: state_n = FAULT;
        endcase

        // No side effects while reset is held, whatever the current state
        if (reset) begin
            pc_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            link_wr    = 1'b0;
            flag_write = 2'b00;
            state_n    = FETCH;
        end
    end

    assign bus.PCWrite    = pc_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.MemRead    = mem_read;
    assign bus.MemWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.RegWrite   = reg_write;
    assign bus.LinkWr     = link_wr;
    assign bus.RegSrc     = reg_src;
    assign bus.ImmSrc     = imm_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_control;
    assign bus.ResultSrc  = result_src;
    assign bus.Fault      = (state_q == FAULT);

endmodule

// File: tb/tb_arm_mc_controller.sv
// Scoreboard bench for arm_mc_controller: per-cycle expected control words are
// queued as stimulus is driven and compared on the following falling edge.
module tb_arm_mc_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset2 = 1'b1;
    always #5 clk = ~clk;

    arm_mc_if m ();
    arm_mc_if m2 ();

    arm_mc_controller #(.HAS_BL(1'b1), .MEMRDY_EN(1'b1), .WAIT_LIMIT(16)) dut (
        .clk(clk), .reset(reset), .bus(m.master));

    arm_mc_controller #(.HAS_BL(1'b0), .MEMRDY_EN(1'b1), .WAIT_LIMIT(16)) dut_nobl (
        .clk(clk), .reset(reset2), .bus(m2.master));

    typedef enum int {
        T_FETCH, T_DECODE, T_EXECR, T_EXECI, T_ALUWB, T_MEMADR,
        T_MEMRD, T_MEMWR, T_MEMWB, T_LINK, T_BRANCH, T_FAULT
    } tst_t;

    typedef struct packed {
        logic       pcw, adr, mrd, mwr, irw, rgw, lnk;
        logic [1:0] regsrc, immsrc;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] aluc;
        logic [1:0] ress;
    } ctl_t;

    typedef struct { tst_t st; logic mrdy; } cyc_t;
    typedef struct { tst_t st; ctl_t e; ctl_t mk; logic [3:0] fl; logic flt; } exp_t;

    cyc_t plan[$];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic [3:0] fl_model = 4'b0000;
    logic saw_link2 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // Expected controls per state as tabulated for the datapath; unspecified selects masked out
    function automatic void ctl_exp(input tst_t s, input bit rd15, input bit mrdy,
                                    input logic [2:0] aluc, output ctl_t e, output ctl_t mk);
        e = '0;
        mk = '0;
        {mk.pcw, mk.mrd, mk.mwr, mk.irw, mk.rgw, mk.lnk} = 6'b111111;
        case (s)
            T_FETCH: begin
                e.mrd = 1'b1; e.irw = mrdy; e.pcw = mrdy;
                mk.adr = 1'b1; e.srca = 1'b1; mk.srca = 1'b1;
                e.srcb = 2'b10; mk.srcb = '1; mk.aluc = '1; e.ress = 2'b10; mk.ress = '1;
            end
            T_DECODE: begin
                e.srca = 1'b1; mk.srca = 1'b1; e.srcb = 2'b10; mk.srcb = '1;
                e.ress = 2'b10; mk.ress = '1;
            end
            T_EXECR, T_EXECI: begin
                mk.srca = 1'b1; mk.srcb = '1; e.srcb = (s == T_EXECI) ? 2'b01 : 2'b00;
                mk.immsrc = (s == T_EXECI) ? 2'b11 : 2'b00;
                e.aluc = aluc; mk.aluc = '1;
            end
            T_ALUWB, T_MEMWB: begin
                e.pcw = rd15; e.rgw = ~rd15; mk.ress = '1;
                e.ress = (s == T_MEMWB) ? 2'b01 : 2'b00;
            end
            T_MEMADR: begin
                mk.srca = 1'b1; e.srcb = 2'b01; mk.srcb = '1;
                e.immsrc = 2'b01; mk.immsrc = '1; mk.aluc = '1;
            end
            T_MEMRD: begin e.adr = 1'b1; mk.adr = 1'b1; e.mrd = 1'b1; end
            T_MEMWR: begin
                e.adr = 1'b1; mk.adr = 1'b1; e.mwr = 1'b1;
                e.regsrc = 2'b10; mk.regsrc = 2'b10;
            end
            T_LINK: begin
                e.srca = 1'b1; mk.srca = 1'b1; e.srcb = 2'b11; mk.srcb = '1; mk.aluc = '1;
                e.ress = 2'b10; mk.ress = '1; e.rgw = 1'b1; e.lnk = 1'b1;
            end
            T_BRANCH: begin
                e.regsrc = 2'b01; mk.regsrc = 2'b01; mk.srca = 1'b1;
                e.srcb = 2'b01; mk.srcb = '1; e.immsrc = 2'b10; mk.immsrc = '1;
                mk.aluc = '1; e.ress = 2'b10; mk.ress = '1; e.pcw = 1'b1;
            end
            default: ;
        endcase
    endfunction

    task automatic plan_add(input tst_t st, input logic mrdy, input int n);
        cyc_t c;
        c.st = st;
        c.mrdy = mrdy;
        repeat (n) plan.push_back(c);
    endtask

    // Enters and leaves at posedge+1; one planned cycle per clock
    task automatic run(input logic [19:0] ins, input logic [3:0] af,
                       input logic [2:0] aluc, input logic [3:0] f_after);
        cyc_t c;
        exp_t x;
        bit   rd15;
        rd15 = (ins[3:0] == 4'hF);
        m.Instr = ins;
        m.ALUFlags = af;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            m.MemReady = c.mrdy;
            ctl_exp(c.st, rd15, c.mrdy, aluc, x.e, x.mk);
            x.st = c.st;
            x.fl = fl_model;
            x.flt = (c.st == T_FAULT);
            sb.push_back(x);
            if (c.st == T_EXECR || c.st == T_EXECI) fl_model = f_after;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m.MemReady = 1'b1;
        @(negedge clk);
        check("rst_enables", 32'({m.PCWrite, m.MemRead, m.MemWrite, m.IRWrite, m.RegWrite, m.LinkWr}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        fl_model = 4'b0000;
        check("rst_flags", 32'(m.Flags), 32'd0);
        check("rst_fault", 32'(m.Fault), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t x;
        ctl_t a;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            a = {m.PCWrite, m.AdrSrc, m.MemRead, m.MemWrite, m.IRWrite, m.RegWrite, m.LinkWr,
                 m.RegSrc, m.ImmSrc, m.ALUSrcA, m.ALUSrcB, m.ALUControl, m.ResultSrc};
            check($sformatf("ctl_%s", x.st.name()), 32'(a & x.mk), 32'(x.e & x.mk));
            check($sformatf("flags_%s", x.st.name()), 32'(m.Flags), 32'(x.fl));
            check($sformatf("fault_%s", x.st.name()), 32'(m.Fault), 32'(x.flt));
        end
        if (!reset2 && m2.LinkWr) saw_link2 = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        m2.Instr = 20'hEB000;
        m2.ALUFlags = 4'b0000;
        m2.MemReady = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset2 = 1'b0;
    end

    initial begin
        m.Instr = 20'h00000;
        m.ALUFlags = 4'b0000;
        m.MemReady = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // ADDS R1,R0,#5 giving zero with carry
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1); plan_add(T_EXECI, 1, 1); plan_add(T_ALUWB, 1, 1);
        run(20'hE2901, 4'b0110, 3'b000, 4'b0110);
        // ANDNE with Z=1: skipped, flags untouched despite hostile ALUFlags
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1);
        run(20'h10032, 4'b1111, 3'b010, 4'b0110);
        // ORRS: NZ from ALU, CV kept
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1); plan_add(T_EXECR, 1, 1); plan_add(T_ALUWB, 1, 1);
        run(20'hE1966, 4'b1000, 3'b011, 4'b1010);
        // CMP R1,R1 then BEQ taken, BNE skipped
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1); plan_add(T_EXECR, 1, 1);
        run(20'hE1510, 4'b0110, 3'b001, 4'b0110);
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1); plan_add(T_BRANCH, 1, 1);
        run(20'h0A000, 4'b0000, 3'b000, 4'b0110);
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1);
        run(20'h1A000, 4'b0000, 3'b000, 4'b0110);
        // MOV PC,R2 without S: PCWrite instead of RegWrite, flags kept
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1); plan_add(T_EXECR, 1, 1); plan_add(T_ALUWB, 1, 1);
        run(20'hE1A0F, 4'b1111, 3'b101, 4'b0110);
        // EORS imm: NZ only
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1); plan_add(T_EXECI, 1, 1); plan_add(T_ALUWB, 1, 1);
        run(20'hE2332, 4'b1001, 3'b100, 4'b1010);
        // CMP sets 1011, then TSTS R5,#0x80 keeps C,V
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1); plan_add(T_EXECR, 1, 1);
        run(20'hE1510, 4'b1011, 3'b001, 4'b1011);
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1); plan_add(T_EXECI, 1, 1);
        run(20'hE3150, 4'b0000, 3'b010, 4'b0011);
        // SUB without S after two fetch wait states
        plan_add(T_FETCH, 0, 2); plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1);
        plan_add(T_EXECR, 1, 1); plan_add(T_ALUWB, 1, 1);
        run(20'hE0421, 4'b1100, 3'b001, 4'b0011);
        // LDR with 3 wait cycles in MEMRD
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1); plan_add(T_MEMADR, 1, 1);
        plan_add(T_MEMRD, 0, 3); plan_add(T_MEMRD, 1, 1); plan_add(T_MEMWB, 1, 1);
        run(20'hE5903, 4'b0000, 3'b000, 4'b0011);
        // STR with 2 wait cycles in MEMWR
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1); plan_add(T_MEMADR, 1, 1);
        plan_add(T_MEMWR, 0, 2); plan_add(T_MEMWR, 1, 1);
        run(20'hE5803, 4'b0000, 3'b000, 4'b0011);
        // LDR PC
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1); plan_add(T_MEMADR, 1, 1);
        plan_add(T_MEMRD, 1, 1); plan_add(T_MEMWB, 1, 1);
        run(20'hE590F, 4'b0000, 3'b000, 4'b0011);
        // LDR with 15 wait cycles: one short of the limit
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1); plan_add(T_MEMADR, 1, 1);
        plan_add(T_MEMRD, 0, 15); plan_add(T_MEMRD, 1, 1); plan_add(T_MEMWB, 1, 1);
        run(20'hE5903, 4'b0000, 3'b000, 4'b0011);
        // BL
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1); plan_add(T_LINK, 1, 1); plan_add(T_BRANCH, 1, 1);
        run(20'hEB000, 4'b0000, 3'b000, 4'b0011);
        // LDR timeout after 16 wait cycles, then reset recovers
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1); plan_add(T_MEMADR, 1, 1);
        plan_add(T_MEMRD, 0, 16); plan_add(T_FAULT, 0, 2);
        run(20'hE5903, 4'b0000, 3'b000, 4'b0011);
        do_reset();
        // Fetch timeout
        plan_add(T_FETCH, 0, 16); plan_add(T_FAULT, 1, 1);
        run(20'hE2901, 4'b0000, 3'b000, 4'b0000);
        do_reset();
        // Illegal encodings: RSB, CMP without S, cond 1111, op 11
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1); plan_add(T_FAULT, 1, 2);
        run(20'hE0601, 4'b1111, 3'b000, 4'b0000);
        do_reset();
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1); plan_add(T_FAULT, 1, 1);
        run(20'hE1410, 4'b1111, 3'b000, 4'b0000);
        do_reset();
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1); plan_add(T_FAULT, 1, 1);
        run(20'hF2901, 4'b1111, 3'b000, 4'b0000);
        do_reset();
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1); plan_add(T_FAULT, 1, 1);
        run(20'hEC000, 4'b1111, 3'b000, 4'b0000);
        do_reset();
        // Reset in the middle of a read wait, then a normal ADDS
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1); plan_add(T_MEMADR, 1, 1); plan_add(T_MEMRD, 0, 2);
        run(20'hE5903, 4'b0000, 3'b000, 4'b0000);
        do_reset();
        plan_add(T_FETCH, 1, 1); plan_add(T_DECODE, 1, 1); plan_add(T_EXECI, 1, 1); plan_add(T_ALUWB, 1, 1);
        run(20'hE2901, 4'b0110, 3'b000, 4'b0110);

        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("nobl_fault", 32'(m2.Fault), 32'd1);
        check("nobl_no_link", 32'(saw_link2), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arm_mc_controller.md
Name: arm_mc_controller

Overview:
Multicycle control unit for the ARM subset core. It replaces the single-cycle decoder/condlogic pair with a Moore FSM driving a shared-memory multicycle datapath, and keeps the NZCV flag register internally. It extends the op set with EOR, MOV, CMP, TST and BL, and adds memory wait-state handshaking with a timeout fault. It sits inside the arm core beside the multicycle datapath; instruction and data share one memory port.

Parameters:
HAS_BL, 1, 1 enables branch-with-link (funct[24]=1); 0 makes BL decode as fault.
MEMRDY_EN, 1, 1 makes memory states wait for MemReady; 0 treats MemReady as constant 1.
WAIT_LIMIT, 16, consecutive MemReady-low cycles in one memory state before fault (range 1..255).

Ports:
clk  in  1  core clock.
reset  in  1  synchronous, active-high.
Instr  in  20  instruction register bits [31:12].
ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle.
MemReady  in  1  memory completed access this cycle.
PCWrite  out  1  load PC from Result.
AdrSrc  out  1  0 = PC, 1 = ALUOut drives memory address.
MemRead  out  1  memory read request.
MemWrite  out  1  memory write request.
IRWrite  out  1  load instruction register.
RegWrite  out  1  register file write.
LinkWr  out  1  force write address to R14.
RegSrc  out  2  [0] RA1=R15, [1] RA2=Rd (as single-cycle).
ImmSrc  out  2  extend select (00 imm8, 01 imm12, 10 branch).
ALUSrcA  out  1  0 = register A, 1 = PC.
ALUSrcB  out  2  00 register, 01 ExtImm, 10 const 4, 11 const 0.
ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 pass-B.
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
Flags  out  4  registered NZCV.
Fault  out  1  sticky fault indicator.

Behaviour:
- Reset (sync): state=FETCH, Flags=0, Fault=0, wait counter=0. All write/request enables are 0 during the reset cycle.
- Outputs are Moore (state only), except PCWrite/RegWrite in writeback, which depend on Rd==15, and MemReady gating.
- FETCH: MemRead, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. On MemReady, assert IRWrite and PCWrite and go to DECODE; otherwise stay.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (R15 reads PC+8). Evaluate cond against Flags using the 15 codes of the existing condcheck. Cond=1111 → FAULT. CondEx=0 → FETCH.
- DECODE dispatch on op:
  - 00 with funct[5]=1 → EXECI; with funct[5]=0 → EXECR.
  - 01 → MEMADR.
  - 10 → LINK if funct[24]=1 and HAS_BL, else BRANCH.
  - 11 → FAULT.
- Illegal encodings → FAULT from DECODE:
  - cmd not in {ADD 0100, SUB 0010, AND 0000, ORR 1100, EOR 0001, MOV 1101, CMP 1010, TST 1000}.
  - CMP or TST with S=0.
  - BL when HAS_BL=0.
- EXECR/EXECI: ALUSrcA=0, ALUSrcB=00 or 01, ImmSrc=00, ALUControl from cmd (CMP→SUB, TST→AND).
  - If S=1: ADD/SUB/CMP write all of NZCV; AND/ORR/EOR/MOV/TST write NZ only, keeping CV.
  - CMP/TST (NoWrite) → FETCH; others → ALUWB.
- ALUWB: ResultSrc=00. If Rd=15, PCWrite=1 and RegWrite=0; else RegWrite=1. → FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ImmSrc=01, ADD. L=1 → MEMRD; L=0 → MEMWR.
- MEMRD: AdrSrc=1, MemRead. On MemReady → MEMWB.
- MEMWR: AdrSrc=1, RegSrc[1]=1, MemWrite held until MemReady, then → FETCH.
- MEMWB: ResultSrc=01, RegWrite (or PCWrite if Rd=15). → FETCH.
- LINK: ALUSrcA=1, ALUSrcB=11, ADD, ResultSrc=10, RegWrite, LinkWr (R14 ← PC, the return address). → BRANCH.
- BRANCH: RegSrc[0]=1, ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ADD, ResultSrc=10, PCWrite. → FETCH.
- Wait counter:
  - Increments in FETCH/MEMRD/MEMWR while MemReady=0; clears on state change.
  - On reaching WAIT_LIMIT, go to FAULT.
- FAULT: all enables 0, Fault=1; left only by reset.
- Reset asserted in any state (including mid-wait) returns to FETCH next cycle with no write performed that cycle.
- Latencies at zero wait: DP 4 cycles, CMP/TST 3, LDR 5, STR 4, B 3, BL 4, skipped (cond false) 2.

Decomposition:
- arm_mc_pkg holds:
  - state_t enum: FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMRD, MEMWR, MEMWB, LINK, BRANCH, FAULT.
  - ALUControl, ALUSrcB and ResultSrc code constants.
  - cmd encodings.
- One sub-module, arm_mc_condunit: flag register (split NZ/CV enables), cond evaluation, CondEx output.

Test Plan:
- ADDS R1,R0,#5 with R0=0xFFFFFFFB, no waits → 4 cycles; RegWrite to R1 at cycle 4; Flags=0110 (Z,C).
- CMP R1,R1 then BEQ +2 → CMP takes 3 cycles with no RegWrite and Flags Z=1; branch PCWrite target = PC+8+8.
- LDR with MemReady low for 3 cycles in MEMRD → MEMRD held 4 cycles, MEMWB once, total 8 cycles; MemReady low for 16 cycles → Fault=1, then reset clears it.
- BL at 0x20 with HAS_BL=1 → LINK writes 0x24 with LinkWr=1; BRANCH sets PC=target. With HAS_BL=0, same word → FAULT.
- ANDNE R2,R3,R4 with Z=1 → DECODE→FETCH, no RegWrite, Flags unchanged.
- TSTS R5,#0x80 with R5=0x80 and prior C=1,V=1 → Flags=0011 (N=0, Z=0, C and V preserved).
